// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 serial transmitter. A small circular FIFO feeds a shift-register
// FSM that drives txd from a flop. Status flags are registered for polling.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte back-to-back if one is queued
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_we_i,
  output logic                          tx_full_o,
  output logic                          tx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count_o,
  output logic                          txd
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              busy_q, busy_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic bit_end;

  assign push    = tx_we_i && !full_q;
  assign bit_end = (cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            // shift_q[1] is the bit that becomes shift[0] after this edge
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d = (count_d == FULL_CNT);
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data_i;
    end
  end

  assign txd        = txd_q;
  assign tx_full_o  = full_q;
  assign tx_busy_o  = busy_q;
  assign tx_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a small instance (DIV=8, depth 4) checked every cycle
// against a frame-timeline model, plus a default-parameter instance timed by hand.
module tb_uart_tx_fifo;

  localparam int DIV_A   = 8;
  localparam int DEP_A   = 4;
  localparam int FRAME_A = 10 * DIV_A;
  localparam int DIV_C   = 5208;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] a_data = 8'h00;
  logic       a_we   = 1'b0;
  logic       a_full, a_busy, a_txd;
  logic [2:0] a_count;

  logic [7:0] c_data = 8'h00;
  logic       c_we   = 1'b0;
  logic       c_full, c_busy, c_txd;
  logic [4:0] c_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .FIFO_DEPTH(DEP_A)) dut_a (
    .clk(clk), .rst(rst), .tx_data_i(a_data), .tx_we_i(a_we),
    .tx_full_o(a_full), .tx_busy_o(a_busy), .tx_count_o(a_count), .txd(a_txd)
  );

  uart_tx_fifo dut_c (
    .clk(clk), .rst(rst), .tx_data_i(c_data), .tx_we_i(c_we),
    .tx_full_o(c_full), .tx_busy_o(c_busy), .tx_count_o(c_count), .txd(c_txd)
  );

  // Model: a byte queue plus the position (in cycles) inside the current frame.
  logic [7:0] q[$];
  logic       m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;

  always @(posedge clk) begin
    int  sz;
    bit  full_now;
    if (rst) begin
      q.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      sz       = q.size();
      full_now = (sz == DEP_A);
      if (m_active && m_pos < FRAME_A - 1) begin
        m_pos++;
      end else if (sz > 0) begin
        m_byte   = q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else begin
        m_active = 1'b0;
      end
      if (a_we && !full_now) q.push_back(a_data);
    end
  end

  function automatic logic line_level(logic [7:0] b, int pos);
    int k;
    k = pos / DIV_A;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle, then compare dut_a against the model away from the edge.
  task automatic cyc();
    logic e_txd;
    @(posedge clk);
    @(negedge clk);
    e_txd = m_active ? line_level(m_byte, m_pos) : 1'b1;
    chk("m_txd",   int'(a_txd),   int'(e_txd));
    chk("m_count", int'(a_count), q.size());
    chk("m_full",  int'(a_full),  int'(q.size() == DEP_A));
    chk("m_busy",  int'(a_busy),  int'(m_active || q.size() != 0));
  endtask

  task automatic rx_byte(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    while (a_txd !== 1'b0 && n < 200) begin
      cyc();
      n++;
    end
    chk("rx_start_seen", int'(n < 200), 1);
    repeat (DIV_A / 2) cyc();
    for (int i = 0; i < 8; i++) begin
      repeat (DIV_A) cyc();
      b[i] = a_txd;
    end
    repeat (DIV_A) cyc();
    chk("rx_stop_bit", int'(a_txd), 1);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] a5_bits;
    int n, zeros, busy_seen, t0;
    int exp_cnt[6];
    int exp_full[6];
    exp_cnt  = '{1, 1, 2, 3, 4, 4};
    exp_full = '{0, 0, 0, 0, 1, 1};
    a5_bits  = 8'hA5;

    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_txd",     int'(a_txd), 1);
    chk("rst_count",   int'(a_count), 0);
    chk("rst_full",    int'(a_full), 0);
    chk("rst_busy",    int'(a_busy), 0);
    chk("rst_c_txd",   int'(c_txd), 1);
    chk("rst_c_count", int'(c_count), 0);

    // Single byte 0xA5
    a_we = 1'b1; a_data = 8'hA5;
    cyc();
    a_we = 1'b0;
    chk("a5_count_push", int'(a_count), 1);
    chk("a5_txd_push",   int'(a_txd), 1);
    cyc();
    chk("a5_txd_fall",   int'(a_txd), 0);
    chk("a5_count_pop",  int'(a_count), 0);
    repeat (DIV_A / 2) cyc();
    chk("a5_start_mid",  int'(a_txd), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV_A) cyc();
      chk("a5_data_bit", int'(a_txd), int'(a5_bits[i]));
    end
    repeat (DIV_A) cyc();
    chk("a5_stop_mid",   int'(a_txd), 1);
    chk("a5_busy_stop",  int'(a_busy), 1);
    repeat (DIV_A / 2 - 1) cyc();
    chk("a5_busy_last",  int'(a_busy), 1);
    cyc();
    chk("a5_busy_end",   int'(a_busy), 0);
    chk("a5_count_end",  int'(a_count), 0);

    // Back-to-back 0x00, 0xFF
    a_we = 1'b1; a_data = 8'h00;
    cyc();
    a_data = 8'hFF;
    cyc();
    a_we = 1'b0;
    chk("b2b_start1", int'(a_txd), 0);
    repeat (FRAME_A - 1) cyc();
    chk("b2b_stop1",  int'(a_txd), 1);
    cyc();
    chk("b2b_start2", int'(a_txd), 0);
    n = 0;
    while (a_busy && n < 300) begin
      cyc();
      n++;
    end
    chk("b2b_total_cycles", FRAME_A + n, 160);

    // Overflow with depth 4
    for (int i = 0; i < 6; i++) begin
      a_we = 1'b1; a_data = 8'h10 + 8'(i);
      cyc();
      chk("ovf_count", int'(a_count), exp_cnt[i]);
      chk("ovf_full",  int'(a_full),  exp_full[i]);
    end
    a_we = 1'b0;
    repeat (FRAME_A - 5) cyc();
    chk("full_before_pop", int'(a_full), 1);
    a_we = 1'b1; a_data = 8'h77;
    cyc();
    a_we = 1'b0;
    chk("pushpop_full_count", int'(a_count), 3);
    chk("pushpop_full_flag",  int'(a_full), 0);
    chk("pushpop_txd_start",  int'(a_txd), 0);
    for (int k = 1; k <= 4; k++) begin
      rx_byte(rb);
      chk("ovf_line_byte", int'(rb), 16 + k);
    end
    repeat (20) cyc();
    chk("ovf_drained_busy", int'(a_busy), 0);
    chk("ovf_drained_txd",  int'(a_txd), 1);

    // Reset during bit 3 of 0x3C with two bytes queued
    a_we = 1'b1; a_data = 8'h3C; cyc();
    a_data = 8'h01; cyc();
    a_data = 8'h02; cyc();
    a_we = 1'b0;
    repeat (33) cyc();
    chk("mid_bit3_txd",   int'(a_txd), 1);
    chk("mid_count",      int'(a_count), 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_txd",   int'(a_txd), 1);
    chk("midrst_count", int'(a_count), 0);
    chk("midrst_busy",  int'(a_busy), 0);
    chk("midrst_full",  int'(a_full), 0);
    zeros = 0; busy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (a_txd == 1'b0) zeros++;
      if (a_busy) busy_seen++;
    end
    chk("postrst_txd_low_cycles", zeros, 0);
    chk("postrst_busy_cycles",    busy_seen, 0);

    // Default parameters: 0x55 alternates every bit, so each run is one bit period
    c_we = 1'b1; c_data = 8'h55;
    cyc();
    c_we = 1'b0;
    chk("def_count_push", int'(c_count), 1);
    cyc();
    chk("def_txd_fall", int'(c_txd), 0);
    t0 = 0;
    for (int b = 0; b < 9; b++) begin
      n = 0;
      while (c_txd == 1'(b % 2) && n < 6000) begin
        cyc();
        n++;
      end
      t0 += n;
      chk("def_bit_cycles", n, DIV_C);
    end
    chk("def_stop_txd", int'(c_txd), 1);
    n = 0;
    while (c_busy && n < 6000) begin
      cyc();
      n++;
    end
    chk("def_frame_cycles", t0 + n, 52080);
    chk("def_count_end", int'(c_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
